// File: rtl/hog_frame_ctrl.sv
// hog_frame_ctrl: frame sequencer in front of a HOG window pipeline.
// Gates camera pixels into the pipeline for one frame, tracks the raster
// position of the next accepted pixel, counts detection windows leaving the
// pipeline, and reports completion once all expected windows have appeared.
// Optional feature macro: HOG_CTRL_TIMEOUT_EN -- when defined, a DRAIN that
// stays silent for DRAIN_TIMEOUT cycles is forced to complete and flags
// timeout_err.
module hog_frame_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int IMAGE_WIDTH       = 640,
  parameter int IMAGE_HEIGHT      = 480,
  parameter int WINDOWS_PER_FRAME = 4096,
  parameter int DRAIN_TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_pixel,
  output logic                  src_ready,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_ready,
  input  logic                  win_valid,
  input  logic                  win_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [15:0]           col,
  output logic [15:0]           row,
  output logic [15:0]           win_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] LP_COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LP_ROW_LAST = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] LP_ROW_END  = 16'(IMAGE_HEIGHT);
  localparam logic [15:0] LP_WIN_MAX  = 16'(WINDOWS_PER_FRAME);
  localparam logic [15:0] LP_TO_MAX   = 16'(DRAIN_TIMEOUT);

  state_t      r_state;
  logic        r_busy;
  logic        r_frame_done;
  logic [15:0] r_col;
  logic [15:0] r_row;
  logic [15:0] r_win_count;

  logic w_in_stream;
  logic w_beat;
  logic w_win_hs;
  logic w_win_full;
  logic w_last_col;
  logic w_last_row;
  logic w_to_hit;

  assign w_in_stream = (r_state == S_STREAM);
  assign w_beat      = w_in_stream & src_valid & pix_ready;
  assign w_win_hs    = win_valid & win_ready & ((r_state == S_STREAM) | (r_state == S_DRAIN));
  assign w_win_full  = (r_win_count == LP_WIN_MAX);
  assign w_last_col  = (r_col == LP_COL_LAST);
  assign w_last_row  = (r_row == LP_ROW_LAST);

  // Pixel path is a pure pass-through, only the handshake is gated by state
  assign pix_data  = src_pixel;
  assign pix_valid = w_in_stream & src_valid;
  assign src_ready = w_in_stream & pix_ready;

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign col        = r_col;
  assign row        = r_row;
  assign win_count  = r_win_count;

`ifdef HOG_CTRL_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout_err;

  // The silent-cycle count is fired one edge early so DONE lands exactly
  // DRAIN_TIMEOUT cycles after the last window (or after DRAIN entry)
  assign w_to_hit    = (r_state == S_DRAIN) & ~w_win_hs & ((r_to_cnt + 16'd1) == LP_TO_MAX);
  assign timeout_err = r_timeout_err;

  // Silent-cycle counter: held at zero outside DRAIN, restarted by every window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= 16'd0;
    end else if ((r_state != S_DRAIN) || w_win_hs) begin
      r_to_cnt <= 16'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Sticky timeout flag: set on a forced completion, cleared by an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start && !abort) begin
      r_timeout_err <= 1'b0;
    end else if (w_to_hit && !abort && !w_win_full) begin
      r_timeout_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^LP_TO_MAX;
  assign w_to_hit         = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // Frame sequencer with raster position and window bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_col        <= 16'd0;
      r_row        <= 16'd0;
      r_win_count  <= 16'd0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state     <= S_STREAM;
            r_busy      <= 1'b1;
            r_col       <= 16'd0;
            r_row       <= 16'd0;
            r_win_count <= 16'd0;
          end
        end

        S_STREAM: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (w_win_hs && !w_win_full) begin
              r_win_count <= r_win_count + 16'd1;
            end
            if (w_beat) begin
              if (w_last_col) begin
                r_col <= 16'd0;
                if (w_last_row) begin
                  // Row parks one past the last line for the rest of the frame
                  r_row   <= LP_ROW_END;
                  r_state <= S_DRAIN;
                end else begin
                  r_row <= r_row + 16'd1;
                end
              end else begin
                r_col <= r_col + 16'd1;
              end
            end
          end
        end

        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_win_full || w_to_hit) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end else if (w_win_hs) begin
            r_win_count <= r_win_count + 16'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hog_frame_ctrl.md
HOG_FRAME_CTRL -- requirements
Module: hog_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter IMAGE_WIDTH, default 640, pixels per row.
REQ-003 Parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 Parameter WINDOWS_PER_FRAME, default 4096, detection windows expected per frame.
REQ-005 Parameter DRAIN_TIMEOUT, default 65535, idle DRAIN cycles before forced completion (used only with HOG_CTRL_TIMEOUT_EN).
REQ-006 Ports SHALL be:
 clk  in  1  sole clock, rising edge.
 rst  in  1  reset, asynchronous, active-low.
 start  in  1  frame start request.
 abort  in  1  frame abort request.
 src_valid  in  1  camera pixel valid.
 src_pixel  in  DATA_WIDTH  camera pixel.
 src_ready  out  1  camera pixel ready.
 pix_valid  out  1  pixel valid to HOG pipeline.
 pix_data  out  DATA_WIDTH  pixel to HOG pipeline.
 pix_ready  in  1  HOG pipeline pixel ready.
 win_valid  in  1  monitored window_valid of HOG output.
 win_ready  in  1  monitored window_ready of HOG output.
 busy  out  1  frame in progress.
 frame_done  out  1  one-cycle completion pulse.
 timeout_err  out  1  sticky drain-timeout flag.
 col  out  16  column of next pixel to be accepted.
 row  out  16  row of next pixel to be accepted.
 win_count  out  16  windows observed this frame.

Function
REQ-007 FSM states IDLE, STREAM, DRAIN, DONE; busy SHALL be 1 in every state except IDLE.
REQ-008 IDLE: src_ready=0, pix_valid=0; start=1 with abort=0 -> STREAM next cycle, clearing col, row, win_count, timeout_err.
REQ-009 start outside IDLE SHALL be ignored.
REQ-010 STREAM: pix_valid=src_valid, src_ready=pix_ready, pix_data=src_pixel, combinational, zero latency.
REQ-011 Outside STREAM: pix_valid=0, src_ready=0; pix_data SHALL still equal src_pixel.
REQ-012 Beat = src_valid & pix_ready in STREAM; each beat col+1; at col=IMAGE_WIDTH-1 col wraps to 0 and row+1.
REQ-013 Beat at col=IMAGE_WIDTH-1, row=IMAGE_HEIGHT-1 -> DRAIN next cycle; col, row then hold 0, IMAGE_HEIGHT; no further beats accepted.
REQ-014 Window handshake = win_valid & win_ready; counted only in STREAM and DRAIN; win_count saturates at WINDOWS_PER_FRAME.
REQ-015 DRAIN with win_count=WINDOWS_PER_FRAME (including a count reached during STREAM) -> DONE next cycle.
REQ-016 DONE lasts exactly one cycle, frame_done=1 only there, then IDLE; win_count holds until next start.
REQ-017 abort=1 in STREAM, DRAIN or DONE -> IDLE next cycle, frame_done not asserted, counters hold; abort and start together in IDLE -> stay IDLE.
REQ-018 Last beat and last window in same STREAM cycle -> DRAIN then DONE on consecutive cycles.

Reset
REQ-019 rst=0 SHALL immediately force IDLE, col=0, row=0, win_count=0, busy=0, frame_done=0, timeout_err=0, src_ready=0, pix_valid=0, including mid-frame.
REQ-020 First start is honoured on the first rising edge after rst returns to 1.

Configuration
REQ-021 Macro HOG_CTRL_TIMEOUT_EN defined: 16-bit counter clears on DRAIN entry and on each window handshake, else increments in DRAIN; reaching DRAIN_TIMEOUT -> DONE with timeout_err=1, sticky until next accepted start.
REQ-022 Macro undefined: no counter; DRAIN waits indefinitely; timeout_err tied 0.

Verification (IMAGE_WIDTH=16, IMAGE_HEIGHT=16, WINDOWS_PER_FRAME=4, DRAIN_TIMEOUT=20)
REQ-023 Start, 256 pixels with pix_ready=1, 4 window handshakes in DRAIN -> DRAIN after beat 256, frame_done one cycle after 4th window, busy=0 next.
REQ-024 pix_ready toggling each cycle, src_valid=1 -> exactly 128 beats per 256 cycles, col/row wrap 15->0, row 16 at DRAIN.
REQ-025 All 4 windows during STREAM -> DRAIN one cycle, DONE, frame_done; win_count=4, fifth window not counted.
REQ-026 Abort at row 5 col 3 -> IDLE next cycle, no frame_done; rst=0 mid-DRAIN -> all outputs zero same cycle.
REQ-027 HOG_CTRL_TIMEOUT_EN, 2 windows then silence -> DONE 20 cycles after last handshake, timeout_err=1, cleared by next start.
